keypad_event: RTL

Debounces the raw scan output of the 4x4 keypad scanner and turns each physical key press into a single 4-bit key code, queued for the downstream consumer (digit entry, display, calculator logic). It sits directly downstream of the scanner. It consumes the scanner's per-row hit flag and key code, judges stability over whole scan frames, and emits codes through a small FIFO with a valid/ready handshake.

---
 rtl/keypad_pkg.sv | 14 +
 rtl/key_fifo.sv | 57 +++++
 rtl/keypad_event.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and default frame counts for the keypad event path
package keypad_pkg;

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;
    typedef enum logic [1:0] {FR_NONE, FR_ONE, FR_MULTI} frame_t;
    typedef logic [3:0] key_code_t;

    localparam int unsigned DEF_DEB_FRAMES   = 8;
    localparam int unsigned DEF_REL_FRAMES   = 8;
    localparam int unsigned DEF_FIFO_DEPTH   = 4;
    localparam int unsigned DEF_REPEAT_DELAY = 64;
    localparam int unsigned DEF_REPEAT_RATE  = 16;

endpackage

// File: rtl/key_fifo.sv
// key_fifo: synchronous valid/ready FIFO; pushes into a full FIFO are dropped and flagged sticky
module key_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             ready,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic             ovf_q, ovf_d;
    logic             empty, full, pop, wr;

    // pointer/storage update; a pop frees the slot the same cycle so push+pop while full both succeed
    always_comb begin
        empty = wp_q == rp_q;
        full  = (wp_q - rp_q) == PW'(DEPTH);
        pop   = !empty && ready;
        wr    = push && (!full || pop);
        mem_d = mem_q;
        if (wr) mem_d[wp_q[AW-1:0]] = din;
        wp_d  = wp_q + PW'(wr);
        rp_d  = rp_q + PW'(pop);
        ovf_d = ovf_q | (push && full && !pop);
    end

    // state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            wp_q  <= '0;
            rp_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            mem_q <= mem_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            ovf_q <= ovf_d;
        end
    end

    assign dout     = mem_q[rp_q[AW-1:0]];
    assign valid    = !empty;
    assign overflow = ovf_q;

endmodule

// File: rtl/keypad_event.sv
// keypad_event: frame-based debounce of keypad scanner hits into queued key codes (optional auto-repeat: KEY_REPEAT_EN)
module keypad_event
    import keypad_pkg::*;
#(
    parameter int unsigned DEB_FRAMES   = DEF_DEB_FRAMES,
    parameter int unsigned REL_FRAMES   = DEF_REL_FRAMES,
    parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      numclk,
    input  key_code_t key,
    output key_code_t code,
    output logic      valid,
    input  logic      ready,
    output logic      pressed,
    output logic      overflow
);

    localparam int unsigned CMAX = (DEB_FRAMES > REL_FRAMES) ? DEB_FRAMES : REL_FRAMES;
    localparam int unsigned CW   = $clog2(CMAX) + 1;

    logic [1:0]    fcnt_q, fcnt_d;
    logic          seen_q, seen_d, multi_q, multi_d;
    key_code_t     fkey_q, fkey_d;
    logic          seen_all, multi_all, fe, one, none, hold;
    key_code_t     fcode;
    frame_t        fres;
    state_t        state_q, state_d;
    key_code_t     cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          push, rep_push;

    // frame accumulator; classification folds in the fcnt=3 sample, key is only looked at when numclk=1
    always_comb begin
        fe        = fcnt_q == 2'd3;
        seen_all  = seen_q | numclk;
        multi_all = multi_q | (numclk && seen_q && (key != fkey_q));
        fcode     = seen_q ? fkey_q : key;
        fres      = multi_all ? FR_MULTI : (seen_all ? FR_ONE : FR_NONE);
        one       = fe && (fres == FR_ONE);
        none      = fe && (fres == FR_NONE);
        hold      = one && (fcode == cand_q);
        fcnt_d    = fcnt_q + 2'd1;
        seen_d    = !fe && seen_all;
        multi_d   = !fe && multi_all;
        fkey_d    = fe ? '0 : ((!seen_q && numclk) ? key : fkey_q);
    end

    // press/release FSM; acts only at frame end
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        cnt_inc = cnt_q + CW'(1);
        push    = 1'b0;
        case (state_q)
            IDLE: if (one) begin
                cand_d = fcode;
                cnt_d  = CW'(1);
                if (DEB_FRAMES == 1) begin
                    push    = 1'b1;
                    state_d = PRESSED;
                end else state_d = DEBOUNCE;
            end
            DEBOUNCE: if (fe) begin
                if (hold) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CW'(DEB_FRAMES)) begin
                        push    = 1'b1;
                        state_d = PRESSED;
                    end
                end else if (one) begin
                    cand_d = fcode;
                    cnt_d  = CW'(1);
                end else state_d = IDLE;
            end
            PRESSED: if (none) begin
                cnt_d = CW'(1);
                if (REL_FRAMES == 1) state_d = IDLE;
                else state_d = RELEASE;
            end else if (rep_push) push = 1'b1;
            RELEASE: if (fe) begin
                if (none) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CW'(REL_FRAMES)) state_d = IDLE;
                end else state_d = PRESSED;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef KEY_REPEAT_EN
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RW   = $clog2(RMAX) + 1;

    logic [RW-1:0] rcnt_q, rcnt_d, rcnt_inc, rthr;
    logic          rep_q, rep_d;

    // repeat timer runs only while PRESSED with the same key; any other state clears it
    always_comb begin
        rcnt_inc = rcnt_q + RW'(1);
        rthr     = rep_q ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY);
        rcnt_d   = '0;
        rep_d    = 1'b0;
        rep_push = 1'b0;
        if (state_q == PRESSED) begin
            rcnt_d = rcnt_q;
            rep_d  = rep_q;
            if (hold) begin
                rep_push = rcnt_inc == rthr;
                rcnt_d   = rep_push ? '0 : rcnt_inc;
                rep_d    = rep_q | rep_push;
            end
        end
    end

    // repeat timer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt_q <= '0;
            rep_q  <= 1'b0;
        end else begin
            rcnt_q <= rcnt_d;
            rep_q  <= rep_d;
        end
    end
`else
    logic unused_rep;
    assign unused_rep = ^{REPEAT_DELAY[0], REPEAT_RATE[0]};
    assign rep_push   = 1'b0;
`endif

    // frame and FSM registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q  <= '0;
            seen_q  <= 1'b0;
            multi_q <= 1'b0;
            fkey_q  <= '0;
            state_q <= IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
        end else begin
            fcnt_q  <= fcnt_d;
            seen_q  <= seen_d;
            multi_q <= multi_d;
            fkey_q  <= fkey_d;
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pressed = (state_q == PRESSED) || (state_q == RELEASE);

    key_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(4)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .din      (cand_d),
        .ready    (ready),
        .dout     (code),
        .valid    (valid),
        .overflow (overflow)
    );

endmodule
